// File: rtl/dma_bus_responder.sv
// DMA bus responder: arbitrates the memory bus for a DMA initiator and runs single read/write accesses.
// Optional memory-ready timeout is enabled by defining DMA_RESP_TIMEOUT_EN.
module dma_bus_responder #(
    parameter int padd_size = 24,
    parameter int cmd_size  = 3,
    parameter int fifo_size = 8
) (
    input  logic                 clk0,
    input  logic                 reset,
    input  logic                 dma_bus_req,
    input  logic                 cpu_bus_busy,
    input  logic [cmd_size-1:0]  dma_rd_cmd,
    input  logic [padd_size-1:0] dma_rd_addr,
    input  logic [padd_size-1:0] dma_wr_addr,
    input  logic [fifo_size-1:0] dma_wr_dataout,
    output logic                 dma_bus_grant,
    output logic [fifo_size-1:0] dma_rd_datain,
    output logic                 dma_ack,
    output logic                 dma_err,
    output logic [padd_size-1:0] mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [fifo_size-1:0] mem_wdata,
    input  logic [fifo_size-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic [15:0]          xfer_cnt
);

    localparam logic [cmd_size-1:0] CMD_RD = cmd_size'(1);
    localparam logic [cmd_size-1:0] CMD_WR = cmd_size'(2);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        RD,
        WR,
        ACK
    } state_t;

    state_t               state, state_nxt;
    logic [padd_size-1:0] addr_lat, addr_lat_nxt;
    logic [fifo_size-1:0] data_lat, data_lat_nxt;
    logic [fifo_size-1:0] rd_data_nxt;
    logic [padd_size-1:0] mem_addr_nxt;
    logic [fifo_size-1:0] mem_wdata_nxt;
    logic [15:0]          cnt_nxt;
    logic                 grant_nxt, mem_rd_nxt, mem_wr_nxt, ack_nxt, err_nxt;
    logic                 timeout;

`ifdef DMA_RESP_TIMEOUT_EN
    logic [3:0] wait_cnt, wait_cnt_nxt;

    // Counter reads 15 during the 16th strobe cycle; no ready by then aborts.
    assign timeout = (wait_cnt == 4'hF);

    always_comb begin
        wait_cnt_nxt = '0;
        if (state == RD || state == WR)
            wait_cnt_nxt = wait_cnt + 4'd1;
    end

    always_ff @(posedge clk0) begin
        if (reset)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt_nxt;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        addr_lat_nxt = addr_lat;
        data_lat_nxt = data_lat;
        rd_data_nxt  = dma_rd_datain;
        cnt_nxt      = xfer_cnt;
        err_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (dma_bus_req && !cpu_bus_busy)
                    state_nxt = GRANT;
            end
            GRANT: begin
                if (!dma_bus_req) begin
                    state_nxt = IDLE;
                end else if (dma_rd_cmd == CMD_RD) begin
                    addr_lat_nxt = dma_rd_addr;
                    state_nxt    = RD;
                end else if (dma_rd_cmd == CMD_WR) begin
                    addr_lat_nxt = dma_wr_addr;
                    data_lat_nxt = dma_wr_dataout;
                    state_nxt    = WR;
                end
            end
            RD: begin
                if (mem_ready) begin
                    rd_data_nxt = mem_rdata;
                    cnt_nxt     = xfer_cnt + 16'd1;
                    state_nxt   = ACK;
                end else if (timeout) begin
                    rd_data_nxt = '1;
                    err_nxt     = 1'b1;
                    state_nxt   = ACK;
                end
            end
            WR: begin
                if (mem_ready) begin
                    cnt_nxt   = xfer_cnt + 16'd1;
                    state_nxt = ACK;
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = dma_bus_req ? GRANT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered values line up with the state they describe.
        grant_nxt     = (state_nxt != IDLE);
        mem_rd_nxt    = (state_nxt == RD);
        mem_wr_nxt    = (state_nxt == WR);
        ack_nxt       = (state_nxt == ACK);
        mem_addr_nxt  = (mem_rd_nxt || mem_wr_nxt) ? addr_lat_nxt : '0;
        mem_wdata_nxt = mem_wr_nxt ? data_lat_nxt : '0;
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            state         <= IDLE;
            addr_lat      <= '0;
            data_lat      <= '0;
            dma_bus_grant <= 1'b0;
            dma_rd_datain <= '0;
            dma_ack       <= 1'b0;
            dma_err       <= 1'b0;
            mem_addr      <= '0;
            mem_rd        <= 1'b0;
            mem_wr        <= 1'b0;
            mem_wdata     <= '0;
            xfer_cnt      <= '0;
        end else begin
            state         <= state_nxt;
            addr_lat      <= addr_lat_nxt;
            data_lat      <= data_lat_nxt;
            dma_bus_grant <= grant_nxt;
            dma_rd_datain <= rd_data_nxt;
            dma_ack       <= ack_nxt;
            dma_err       <= err_nxt;
            mem_addr      <= mem_addr_nxt;
            mem_rd        <= mem_rd_nxt;
            mem_wr        <= mem_wr_nxt;
            mem_wdata     <= mem_wdata_nxt;
            xfer_cnt      <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_dma_bus_responder.sv
// Bench for dma_bus_responder: transaction-level reference model, per-cycle compare, directed and random stimulus.
module tb_dma_bus_responder;

    logic        clk0 = 1'b0;
    logic        reset;
    logic        dma_bus_req, cpu_bus_busy;
    logic [2:0]  dma_rd_cmd;
    logic [23:0] dma_rd_addr, dma_wr_addr;
    logic [7:0]  dma_wr_dataout;
    logic        dma_bus_grant;
    logic [7:0]  dma_rd_datain;
    logic        dma_ack, dma_err;
    logic [23:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [15:0] xfer_cnt;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

`ifdef DMA_RESP_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    dma_bus_responder #(.padd_size(24), .cmd_size(3), .fifo_size(8)) dut (
        .clk0(clk0), .reset(reset),
        .dma_bus_req(dma_bus_req), .cpu_bus_busy(cpu_bus_busy),
        .dma_rd_cmd(dma_rd_cmd), .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
        .dma_wr_dataout(dma_wr_dataout), .dma_bus_grant(dma_bus_grant),
        .dma_rd_datain(dma_rd_datain), .dma_ack(dma_ack), .dma_err(dma_err),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .xfer_cnt(xfer_cnt)
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bus ownership, the access in flight (0 none, 1 read, 2 write) and a pending acknowledge.
    bit          m_owned, m_ack, m_err;
    int          m_op, m_waits;
    logic [23:0] m_addr;
    logic [7:0]  m_data, m_rdout;
    logic [15:0] m_cnt;

    always @(posedge clk0) begin
        if (reset) begin
            m_owned = 0; m_ack = 0; m_err = 0; m_op = 0; m_waits = 0;
            m_addr = '0; m_data = '0; m_rdout = '0; m_cnt = '0;
        end else if (m_op != 0) begin
            if (mem_ready) begin
                if (m_op == 1) m_rdout = mem_rdata;
                m_op  = 0;
                m_ack = 1;
                m_cnt = m_cnt + 16'd1;
            end else begin
                m_waits++;
                if (TO_EN && m_waits == 16) begin
                    if (m_op == 1) m_rdout = 8'hFF;
                    m_op  = 0;
                    m_ack = 1;
                    m_err = 1;
                end
            end
        end else if (m_ack) begin
            m_ack   = 0;
            m_err   = 0;
            m_owned = dma_bus_req;
        end else if (m_owned) begin
            if (!dma_bus_req) begin
                m_owned = 0;
            end else if (dma_rd_cmd == 3'b001) begin
                m_op = 1; m_waits = 0; m_addr = dma_rd_addr;
            end else if (dma_rd_cmd == 3'b010) begin
                m_op = 2; m_waits = 0; m_addr = dma_wr_addr; m_data = dma_wr_dataout;
            end
        end else begin
            m_owned = dma_bus_req && !cpu_bus_busy;
        end
    end

    always @(negedge clk0) begin
        if (chk_en) begin
            chk("grant",   dma_bus_grant, m_owned);
            chk("mem_rd",  mem_rd, m_op == 1);
            chk("mem_wr",  mem_wr, m_op == 2);
            chk("addr",    mem_addr, (m_op != 0) ? m_addr : 24'h0);
            chk("wdata",   mem_wdata, (m_op == 2) ? m_data : 8'h0);
            chk("ack",     dma_ack, m_ack);
            chk("err",     dma_err, m_err);
            chk("rd_data", dma_rd_datain, m_rdout);
            chk("cnt",     xfer_cnt, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    initial begin
        int wr_cyc, rd_cyc, ack_seen, lowready;
        logic [15:0] base_cnt;
        logic [7:0]  err_rdata;
        logic        err_flag;

        reset = 1; dma_bus_req = 0; cpu_bus_busy = 0; dma_rd_cmd = 0;
        dma_rd_addr = 0; dma_wr_addr = 0; dma_wr_dataout = 0; mem_rdata = 0; mem_ready = 0;
        tick(); tick();
        reset = 0;
        chk_en = 1;
        @(negedge clk0);
        chk("rst_grant", dma_bus_grant, 0);
        chk("rst_cnt", xfer_cnt, 0);
        chk("rst_ack", dma_ack, 0);

        // Single read, ready on the first strobe
        dma_bus_req = 1; dma_rd_cmd = 3'b001; dma_rd_addr = 24'h000123; mem_rdata = 8'h5A; mem_ready = 1;
        @(negedge clk0);
        chk("rd_grant", dma_bus_grant, 1);
        chk("rd_nostrobe", mem_rd, 0);
        @(negedge clk0);
        chk("rd_strobe", mem_rd, 1);
        chk("rd_addr", mem_addr, 24'h000123);
        dma_rd_cmd = 3'b000;
        @(negedge clk0);
        chk("rd_ack", dma_ack, 1);
        chk("rd_datain", dma_rd_datain, 8'h5A);
        chk("rd_cnt", xfer_cnt, 1);
        @(negedge clk0);
        chk("rd_ack_pulse", dma_ack, 0);
        chk("rd_hold", dma_rd_datain, 8'h5A);

        // Write with ready on the third strobe cycle
        dma_rd_cmd = 3'b010; dma_wr_addr = 24'h00ABCD; dma_wr_dataout = 8'hC3; mem_ready = 0;
        wr_cyc = 0; ack_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk0);
            if (mem_wr) begin
                wr_cyc++;
                dma_rd_cmd = 3'b000;
                if (wr_cyc == 1) begin
                    chk("wr_addr", mem_addr, 24'h00ABCD);
                    chk("wr_wdata", mem_wdata, 8'hC3);
                end
            end
            if (dma_ack) ack_seen++;
            mem_ready = mem_wr && (wr_cyc == 3);
        end
        chk("wr_cycles", wr_cyc, 3);
        chk("wr_acks", ack_seen, 1);
        chk("wr_cnt", xfer_cnt, 2);

        // Arbitration against a busy CPU
        dma_bus_req = 0;
        @(negedge clk0); @(negedge clk0);
        cpu_bus_busy = 1; dma_bus_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk0);
            chk("busy_grant", dma_bus_grant, 0);
        end
        cpu_bus_busy = 0;
        @(negedge clk0);
        chk("busy_release", dma_bus_grant, 1);

        // Request dropped while a read is in flight
        dma_rd_cmd = 3'b001; dma_rd_addr = 24'h0F0F0F; mem_ready = 0;
        @(negedge clk0);
        chk("drop_strobe", mem_rd, 1);
        dma_rd_cmd = 3'b000; dma_bus_req = 0;
        @(negedge clk0);
        mem_ready = 1; mem_rdata = 8'h3C;
        @(negedge clk0);
        chk("drop_ack", dma_ack, 1);
        chk("drop_data", dma_rd_datain, 8'h3C);
        mem_ready = 0;
        @(negedge clk0);
        chk("drop_idle", dma_bus_grant, 0);
        chk("drop_cnt", xfer_cnt, 3);

        // Reset in the middle of a write
        dma_bus_req = 1;
        @(negedge clk0);
        dma_rd_cmd = 3'b010; dma_wr_addr = 24'h55AA55; dma_wr_dataout = 8'h99;
        @(negedge clk0);
        chk("rstw_strobe", mem_wr, 1);
        dma_rd_cmd = 3'b000; reset = 1;
        @(negedge clk0);
        chk("rstw_grant", dma_bus_grant, 0);
        chk("rstw_wr", mem_wr, 0);
        chk("rstw_addr", mem_addr, 0);
        chk("rstw_wdata", mem_wdata, 0);
        chk("rstw_cnt", xfer_cnt, 0);
        chk("rstw_rdata", dma_rd_datain, 0);
        reset = 0; dma_bus_req = 0; mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk0);
            chk("rstw_noack", dma_ack, 0);
        end
        mem_ready = 0;

        // Read with no memory response
        dma_bus_req = 1;
        @(negedge clk0);
        base_cnt = xfer_cnt;
        dma_rd_cmd = 3'b001; dma_rd_addr = 24'h000777;
        rd_cyc = 0; ack_seen = 0; err_flag = 0; err_rdata = 0;
`ifdef DMA_RESP_TIMEOUT_EN
        for (int i = 0; i < 40 && ack_seen == 0; i++) begin
            @(negedge clk0);
            if (mem_rd) begin rd_cyc++; dma_rd_cmd = 3'b000; end
            if (dma_ack) begin ack_seen = 1; err_flag = dma_err; err_rdata = dma_rd_datain; end
        end
        chk("to_strobes", rd_cyc, 16);
        chk("to_ack", ack_seen, 1);
        chk("to_err", err_flag, 1);
        chk("to_rdata", err_rdata, 8'hFF);
        chk("to_cnt", xfer_cnt, base_cnt);
`else
        for (int i = 0; i < 30; i++) begin
            @(negedge clk0);
            if (mem_rd) begin rd_cyc++; dma_rd_cmd = 3'b000; end
            if (dma_ack) ack_seen++;
        end
        chk("wait_strobes", rd_cyc, 30);
        chk("wait_noack", ack_seen, 0);
        mem_ready = 1; mem_rdata = 8'h77;
        @(negedge clk0);
        chk("wait_ack", dma_ack, 1);
        chk("wait_err", dma_err, 0);
        chk("wait_cnt", xfer_cnt, base_cnt + 16'd1);
        mem_ready = 0;
`endif

        // Randomized traffic
        lowready = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk0);
            if (i % 256 == 0) lowready = $urandom_range(0, 1);
            reset          = ($urandom_range(0, 299) == 0);
            dma_bus_req    = ($urandom_range(0, 7) != 0);
            cpu_bus_busy   = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0, 1:    dma_rd_cmd = 3'b001;
                2, 3:    dma_rd_cmd = 3'b010;
                4:       dma_rd_cmd = 3'b000;
                default: dma_rd_cmd = 3'($urandom_range(3, 7));
            endcase
            dma_rd_addr    = 24'($urandom);
            dma_wr_addr    = 24'($urandom);
            dma_wr_dataout = 8'($urandom);
            mem_rdata      = 8'($urandom);
            mem_ready      = lowready ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 2) == 0);
        end

        reset = 0; dma_bus_req = 0; mem_ready = 1;
        repeat (4) @(negedge clk0);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
